// File: rtl/common_pkg.sv
// Shared types for the RV64 execute stage: ALU operation encoding and request/response bundles.
package common;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ALU_CTR_W = 4;
  localparam int unsigned RD_W      = 5;

  typedef enum logic [ALU_CTR_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110
  } ALU_CTR;

  typedef struct packed {
    ALU_CTR            alu_ctrl;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic [XLEN-1:0]   store_data;
  } exe_req_t;

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [XLEN-1:0]   store_data;
  } exe_resp_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: operation select on two operands, plus an equality flag that
// ignores the selected operation so beq works whatever ALU_CTR carries.
module alu_core
  import common::*;
#(
  parameter int unsigned W = XLEN
) (
  input  ALU_CTR         i_alu_ctrl,
  input  logic [W-1:0]   i_src1,
  input  logic [W-1:0]   i_src2,
  output logic [W-1:0]   o_result_c,
  output logic           o_zero_c
);

  logic [W-1:0] w_diff;

  assign w_diff   = i_src1 - i_src2;
  assign o_zero_c = (w_diff == '0);

  always_comb begin
    o_result_c = i_src1 & i_src2;
    case (i_alu_ctrl)
      ALU_ADD: o_result_c = i_src1 + i_src2;
      ALU_SUB: o_result_c = w_diff;
      ALU_AND: o_result_c = i_src1 & i_src2;
      ALU_OR:  o_result_c = i_src1 | i_src2;
      ALU_XOR: o_result_c = i_src1 ^ i_src2;
      default: o_result_c = i_src1 & i_src2;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU + single-entry pipeline register with valid/ready handshake,
// registered branch redirect toward fetch and an accepted-instruction counter.
module exe_stage #(
  parameter int unsigned XLEN  = common::XLEN,
  parameter int unsigned CNT_W = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  common::ALU_CTR      in_alu_ctrl,
  input  logic [XLEN-1:0]     in_src1,
  input  logic [XLEN-1:0]     in_src2,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [4:0]          in_rd,
  input  logic                in_reg_write,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic                in_branch,
  input  logic [XLEN-1:0]     in_store_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [4:0]          out_rd,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic [XLEN-1:0]     out_store_data,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [CNT_W-1:0]    retired_cnt
);

  logic [XLEN-1:0]  w_result;
  logic             w_zero;
  logic             w_accept;
  logic             w_taken;
  logic [XLEN-1:0]  w_target;

  logic             r_valid;
  logic [XLEN-1:0]  r_result;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [XLEN-1:0]  r_store_data;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_retired_cnt;

  alu_core #(.W(XLEN)) u_alu (
    .i_alu_ctrl (in_alu_ctrl),
    .i_src1     (in_src1),
    .i_src2     (in_src2),
    .o_result_c (w_result),
    .o_zero_c   (w_zero)
  );

  // A flush frees the slot: whatever is offered alongside it is consumed and dropped.
  assign in_ready = !r_valid || out_ready || flush;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_taken  = w_accept && in_branch && w_zero;
  assign w_target = in_pc + in_imm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid          <= 1'b0;
      r_result         <= '0;
      r_rd             <= '0;
      r_reg_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_store_data     <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_retired_cnt    <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid      <= 1'b1;
        r_result     <= w_result;
        r_rd         <= in_rd;
        r_reg_write  <= in_reg_write;
        r_mem_read   <= in_mem_read;
        r_mem_write  <= in_mem_write;
        r_store_data <= in_store_data;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      r_redirect_valid <= w_taken;
      if (w_taken) begin
        r_redirect_pc <= w_target;
      end
      if (w_accept) begin
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_result     = r_result;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;
  assign out_mem_read   = r_mem_read;
  assign out_mem_write  = r_mem_write;
  assign out_store_data = r_store_data;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign retired_cnt    = r_retired_cnt;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios plus random traffic, with a scoreboard fed
// by a transaction-level model and drained by an independent output monitor.
module tb_exe_stage;
  import common::*;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  ALU_CTR           in_alu_ctrl;
  logic [63:0]      in_src1, in_src2, in_pc, in_imm, in_store_data;
  logic [4:0]       in_rd;
  logic             in_reg_write, in_mem_read, in_mem_write, in_branch;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result, out_store_data;
  logic [4:0]       out_rd;
  logic             out_reg_write, out_mem_read, out_mem_write;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic [63:0]      retired_cnt;

  exe_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctrl(in_alu_ctrl),
    .in_src1(in_src1), .in_src2(in_src2), .in_pc(in_pc), .in_imm(in_imm),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_branch(in_branch), .in_store_data(in_store_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_store_data(out_store_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [63:0] sd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Transaction-level model of what the stage should present
  logic        m_valid;
  logic        m_redir;
  logic [63:0] m_rpc;
  logic [63:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_alu(input ALU_CTR op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return a & b;
    endcase
  endfunction

  task automatic set_in(input logic v, input ALU_CTR op, input logic [63:0] s1,
                        input logic [63:0] s2, input logic [63:0] pc, input logic [63:0] imm,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic br, input logic [63:0] sd, input logic fl,
                        input logic ordy);
    in_valid = v; in_alu_ctrl = op; in_src1 = s1; in_src2 = s2; in_pc = pc; in_imm = imm;
    in_rd = rd; in_reg_write = rw; in_mem_read = mr; in_mem_write = mw; in_branch = br;
    in_store_data = sd; flush = fl; out_ready = ordy;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_redir = 1'b0; m_rpc = '0; m_cnt = '0;
    sb.delete();
  endtask

  // One clock: check ready, predict, cross the edge, then compare registered outputs
  task automatic step();
    logic exp_rdy, acc, n_valid, n_redir;
    exp_t e;
    #2;
    exp_rdy = !m_valid || out_ready || flush;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy && !flush;
    if (acc) begin
      e.result = ref_alu(in_alu_ctrl, in_src1, in_src2);
      e.rd = in_rd; e.rw = in_reg_write; e.mr = in_mem_read; e.mw = in_mem_write;
      e.sd = in_store_data;
      sb.push_back(e);
    end
    if (flush) n_valid = 1'b0;
    else if (acc) n_valid = 1'b1;
    else if (m_valid && out_ready) n_valid = 1'b0;
    else n_valid = m_valid;
    n_redir = acc && in_branch && (in_src1 == in_src2);
    @(posedge clk);
    // An entry squashed while stalled never reaches the memory stage
    if (flush && m_valid && !out_ready && sb.size() > 0) void'(sb.pop_front());
    if (n_redir) m_rpc = in_pc + in_imm;
    m_redir = n_redir;
    m_valid = n_valid;
    if (acc) m_cnt = m_cnt + 64'd1;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("retired_cnt", retired_cnt, m_cnt);
    #1;
  endtask

  // Monitor: just before each rising edge, a transfer pops and compares one entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_result", out_result, e.result);
          chk("out_rd", 64'(out_rd), 64'(e.rd));
          chk("out_reg_write", 64'(out_reg_write), 64'(e.rw));
          chk("out_mem_read", 64'(out_mem_read), 64'(e.mr));
          chk("out_mem_write", 64'(out_mem_write), 64'(e.mw));
          chk("out_store_data", out_store_data, e.sd);
        end
      end
    end
  end

  localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

  initial begin
    logic [63:0] held;
    model_reset();
    set_in(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt", retired_cnt, 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;

    // ADD then SUB back-to-back
    set_in(1, ALU_ADD, 5, 7, 0, 0, 5'd1, 1, 0, 0, 0, 64'h11, 0, 1); step();
    chk("add_const", out_result, 64'd12);
    set_in(1, ALU_SUB, 3, 5, 0, 0, 5'd2, 1, 0, 0, 0, 64'h22, 0, 1); step();
    chk("sub_const", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cnt_two", retired_cnt, 64'd2);

    // Logic ops and an unlisted encoding
    set_in(1, ALU_AND, 64'hF0F0, 64'h0FF0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 1); step();
    chk("and_const", out_result, 64'h00F0);
    set_in(1, ALU_OR, 64'hF0F0, 64'h0FF0, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 1); step();
    chk("or_const", out_result, 64'hFFF0);
    set_in(1, ALU_XOR, 64'hF0F0, 64'h0FF0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 1); step();
    chk("xor_const", out_result, 64'hFF00);
    set_in(1, ALU_CTR'(4'hF), 64'hFF, 64'h0F, 0, 0, 5'd6, 1, 0, 0, 0, 0, 0, 1); step();
    chk("dflt_const", out_result, 64'h0F);

    // beq taken, then idle, then not taken
    set_in(1, ALU_SUB, 9, 9, 64'h100, NEG8, 5'd0, 0, 0, 0, 1, 0, 0, 1); step();
    chk("beq_pulse", 64'(redirect_valid), 64'd1);
    chk("beq_target", redirect_pc, 64'hF8);
    set_in(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("beq_one_cycle", 64'(redirect_valid), 64'd0);
    set_in(1, ALU_SUB, 9, 10, 64'h100, NEG8, 5'd0, 0, 0, 0, 1, 0, 0, 1); step();
    chk("bne_no_pulse", 64'(redirect_valid), 64'd0);

    // Back-pressure for 3 cycles, then release with a new input: no bubble
    set_in(1, ALU_ADD, 64'h1000, 64'h234, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0, 1); step();
    held = out_result;
    for (int i = 0; i < 3; i++) begin
      set_in(1, ALU_ADD, 64'h1, 64'h1, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0); step();
      chk("bp_stable", out_result, 64'h1234);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    set_in(1, ALU_ADD, 64'h1, 64'h1, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 1); step();
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_result", out_result, 64'h2);

    // Flush with a held entry and a taken beq offered alongside
    set_in(1, ALU_ADD, 4, 4, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0); step();
    held = retired_cnt;
    set_in(1, ALU_SUB, 9, 9, 64'h200, NEG8, 5'd0, 0, 0, 0, 1, 0, 1, 0); step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_no_redir", 64'(redirect_valid), 64'd0);
    chk("flush_cnt", retired_cnt, held);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a, b;
      ALU_CTR op;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: op = ALU_ADD; 1: op = ALU_SUB; 2: op = ALU_AND;
        3: op = ALU_OR;  4: op = ALU_XOR; default: op = ALU_CTR'(4'($urandom));
      endcase
      set_in(($urandom_range(0, 3) != 0), op, a, b, {$urandom, $urandom},
             {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      step();
    end

    // Reset in the middle of a held transfer
    set_in(1, ALU_ADD, 64'hAA, 64'h55, 64'h10, 64'h20, 5'd10, 1, 1, 1, 1, 64'h77, 0, 0);
    step();
    set_in(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_result", out_result, 64'd0);
    chk("mrst_rd", 64'(out_rd), 64'd0);
    chk("mrst_ctl", 64'({out_reg_write, out_mem_read, out_mem_write}), 64'd0);
    chk("mrst_sd", out_store_data, 64'd0);
    chk("mrst_redir", 64'(redirect_valid), 64'd0);
    chk("mrst_rpc", redirect_pc, 64'd0);
    chk("mrst_cnt", retired_cnt, 64'd0);
    model_reset();
    @(negedge clk); #1;
    reset_n = 1'b1;
    set_in(1, ALU_ADD, 1, 2, 0, 0, 5'd11, 1, 0, 0, 0, 0, 0, 1); step();
    chk("post_rst_cnt", retired_cnt, 64'd1);
    chk("post_rst_result", out_result, 64'd3);

    // Drain
    set_in(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(); step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
